// File: rtl/epaper_timing_pkg.sv
// Shared timing types, default panel timings and idle pin levels
// for the e-paper frame sequencer and its line timer.
package epaper_timing_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSTART,
    S_LINE,
    S_FEND,
    S_DONE
  } state_t;

  localparam int H_DATA_DEF   = 200;
  localparam int LE_WIDTH_DEF = 3;
  localparam int CKV_LOW_DEF  = 13;
  localparam int V_LINES_DEF  = 600;
  localparam int FRAMES_DEF   = 85;
  localparam int VS_LEN_DEF   = 32;
  localparam int FEND_LEN_DEF = 16;

  localparam int HW = 8;
  localparam int RW = 10;
  localparam int FW = 7;

  typedef logic [HW-1:0] hcnt_t;
  typedef logic [RW-1:0] row_t;
  typedef logic [FW-1:0] frame_t;

  typedef struct packed {
    logic data_en;
    logic sph;
    logic le;
    logic ckv;
    logic spv;
  } pins_t;

  localparam pins_t PINS_IDLE = '{
    data_en: 1'b0,
    sph:     1'b1,
    le:      1'b0,
    ckv:     1'b1,
    spv:     1'b1
  };

  function automatic int line_len(
    input int hd,
    input int lw,
    input int cl
  );
    return hd + lw + cl;
  endfunction

endpackage

// File: rtl/epaper_frame_sequencer_if.sv
// Control/status and panel-pin bundle between the update
// controller and the frame sequencer.
interface epaper_frame_sequencer_if;
  import epaper_timing_pkg::*;

  logic   start;
  logic   abort;
  logic   busy;
  logic   done;
  frame_t frame_idx;
  row_t   row_idx;
  logic   data_en;
  logic   sph;
  logic   le;
  logic   ckv;
  logic   spv;

  modport master (
    output start, abort,
    input  busy, done, frame_idx, row_idx,
    input  data_en, sph, le, ckv, spv
  );

  modport slave (
    input  start, abort,
    output busy, done, frame_idx, row_idx,
    output data_en, sph, le, ckv, spv
  );

endinterface

// File: rtl/epaper_line_timer.sv
// Shared h counter for all busy phases plus the per-phase
// decode of the source and gate pins.
module epaper_line_timer
  import epaper_timing_pkg::*;
#(
  parameter int H_DATA   = H_DATA_DEF,
  parameter int LE_WIDTH = LE_WIDTH_DEF,
  parameter int CKV_LOW  = CKV_LOW_DEF,
  parameter int VS_LEN   = VS_LEN_DEF,
  parameter int FEND_LEN = FEND_LEN_DEF
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   clr,
  input  state_t st,
  output hcnt_t  h,
  output logic   wrap,
  output pins_t  pins
);

  localparam int LINE_LEN =
    line_len(H_DATA, LE_WIDTH, CKV_LOW);

  localparam hcnt_t VS_LAST = hcnt_t'(VS_LEN - 1);
  localparam hcnt_t LN_LAST = hcnt_t'(LINE_LEN - 1);
  localparam hcnt_t FE_LAST = hcnt_t'(FEND_LEN - 1);
  localparam hcnt_t VS_CKV  = hcnt_t'(VS_LEN - CKV_LOW);
  localparam hcnt_t LE_ON   = hcnt_t'(H_DATA);
  localparam hcnt_t LE_OFF  = hcnt_t'(H_DATA + LE_WIDTH);

  logic  run;
  hcnt_t last;

  always_comb begin
    run  = 1'b1;
    last = '0;
    unique case (st)
      S_VSTART: last = VS_LAST;
      S_LINE:   last = LN_LAST;
      S_FEND:   last = FE_LAST;
      default:  run  = 1'b0;
    endcase
  end

  assign wrap = run && (h == last);

  // h parks at 0 outside busy phases so every phase starts clean
  always_ff @(posedge clock) begin
    if (reset || clr || !run || wrap)
      h <= '0;
    else
      h <= h + 1'b1;
  end

  always_comb begin
    pins = PINS_IDLE;
    unique case (1'b1)
      st == S_VSTART: begin
        pins.spv = 1'b0;
        pins.ckv = (h < VS_CKV);
      end
      st == S_LINE: begin
        pins.data_en = (h < LE_ON);
        pins.sph     = (h != '0);
        pins.le      = (h >= LE_ON) && (h < LE_OFF);
        pins.ckv     = (h < LE_OFF);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/epaper_frame_sequencer.sv
// E-paper update sequencer: frame/row counters and the
// update state machine around a shared line timer.
module epaper_frame_sequencer
  import epaper_timing_pkg::*;
#(
  parameter int H_DATA   = H_DATA_DEF,
  parameter int LE_WIDTH = LE_WIDTH_DEF,
  parameter int CKV_LOW  = CKV_LOW_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int FRAMES   = FRAMES_DEF,
  parameter int VS_LEN   = VS_LEN_DEF,
  parameter int FEND_LEN = FEND_LEN_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  epaper_frame_sequencer_if.slave  bus
);

  localparam frame_t F_LAST = frame_t'(FRAMES - 1);
  localparam row_t   R_LAST = row_t'(V_LINES - 1);

  state_t state, state_n;
  frame_t frame, frame_n;
  row_t   row, row_n;
  logic   clr;
  logic   wrap;
  hcnt_t  h;
  pins_t  pins;

  epaper_line_timer #(
    .H_DATA   (H_DATA),
    .LE_WIDTH (LE_WIDTH),
    .CKV_LOW  (CKV_LOW),
    .VS_LEN   (VS_LEN),
    .FEND_LEN (FEND_LEN)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .st    (state),
    .h     (h),
    .wrap  (wrap),
    .pins  (pins)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      frame <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      frame <= frame_n;
      row   <= row_n;
    end
  end

  always_comb begin
    state_n = state;
    frame_n = frame;
    row_n   = row;
    clr     = 1'b0;
    if (bus.abort && state != S_IDLE) begin
      state_n = S_IDLE;
      frame_n = '0;
      row_n   = '0;
      clr     = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_n = S_VSTART;
            frame_n = '0;
            row_n   = '0;
          end
        end
        S_VSTART: begin
          if (wrap) state_n = S_LINE;
        end
        S_LINE: begin
          if (wrap) begin
            if (row == R_LAST)
              state_n = S_FEND;
            else
              row_n = row + 1'b1;
          end
        end
        S_FEND: begin
          if (wrap) begin
            if (frame == F_LAST) begin
              state_n = S_DONE;
            end else begin
              state_n = S_VSTART;
              frame_n = frame + 1'b1;
              row_n   = '0;
            end
          end
        end
        S_DONE: begin
          state_n = S_IDLE;
          frame_n = '0;
          row_n   = '0;
        end
        default: begin
          state_n = S_IDLE;
          frame_n = '0;
          row_n   = '0;
        end
      endcase
    end
  end

  assign bus.busy = (state == S_VSTART) ||
                    (state == S_LINE)   ||
                    (state == S_FEND);
  assign bus.done      = (state == S_DONE);
  assign bus.frame_idx = frame;
  assign bus.row_idx   = row;
  assign bus.data_en   = pins.data_en;
  assign bus.sph       = pins.sph;
  assign bus.le        = pins.le;
  assign bus.ckv       = pins.ckv;
  assign bus.spv       = pins.spv;

endmodule

// File: tb/tb_epaper_frame_sequencer.sv
// Bench for epaper_frame_sequencer: cycle table, directed update
// sequences and random start/abort/reset against a timeline model.
module tb_epaper_frame_sequencer;

  localparam int HD = 4;
  localparam int LW = 1;
  localparam int CK = 2;
  localparam int VL = 3;
  localparam int FR = 2;
  localparam int VS = 4;
  localparam int FE = 2;
  localparam int LL = HD + LW + CK;
  localparam int FP = VS + VL * LL + FE;
  localparam int N  = FR * FP;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [6:0] frame;
    logic [9:0] row;
    logic       de;
    logic       sph;
    logic       le;
    logic       ckv;
    logic       spv;
  } exp_t;

  typedef struct {
    int   cyc;
    exp_t e;
  } vec_t;

  logic clock;
  logic reset;

  epaper_frame_sequencer_if bus();

  epaper_frame_sequencer #(
    .H_DATA   (HD),
    .LE_WIDTH (LW),
    .CKV_LOW  (CK),
    .V_LINES  (VL),
    .FRAMES   (FR),
    .VS_LEN   (VS),
    .FEND_LEN (FE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   nvec = 0;
  int   nmis = 0;
  bit   m_act = 0;
  int   m_k = 0;
  int   cyc_now = 0;
  bit   tbl_on = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  vec_t tbl[$];

  // Expected pins from the position k within an update timeline
  function automatic exp_t model_out(input bit a, input int k);
    exp_t e;
    int   f, r, off, l, hh;
    e = '{busy: 1'b0, done: 1'b0, frame: '0, row: '0,
          de: 1'b0, sph: 1'b1, le: 1'b0, ckv: 1'b1, spv: 1'b1};
    if (!a) return e;
    if (k == N) begin
      e.done  = 1'b1;
      e.frame = 7'(FR - 1);
      e.row   = 10'(VL - 1);
      return e;
    end
    e.busy  = 1'b1;
    f       = k / FP;
    r       = k % FP;
    e.frame = 7'(f);
    if (r < VS) begin
      e.spv = 1'b0;
      e.ckv = (r < VS - CK);
    end else if (r < VS + VL * LL) begin
      off   = r - VS;
      l     = off / LL;
      hh    = off % LL;
      e.row = 10'(l);
      e.de  = (hh < HD);
      e.sph = (hh != 0);
      e.le  = (hh >= HD) && (hh < HD + LW);
      e.ckv = (hh < HD + LW);
    end else begin
      e.row = 10'(VL - 1);
    end
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t e;
    e.busy  = bus.busy;
    e.done  = bus.done;
    e.frame = bus.frame_idx;
    e.row   = bus.row_idx;
    e.de    = bus.data_en;
    e.sph   = bus.sph;
    e.le    = bus.le;
    e.ckv   = bus.ckv;
    e.spv   = bus.spv;
    return e;
  endfunction

  function automatic vec_t mk(
    input int c, input logic b, input logic d,
    input int f, input int r, input logic de,
    input logic sph, input logic le, input logic ckv,
    input logic spv
  );
    vec_t v;
    v.cyc = c;
    v.e = '{busy: b, done: d, frame: 7'(f), row: 10'(r),
            de: de, sph: sph, le: le, ckv: ckv, spv: spv};
    return v;
  endfunction

  task automatic chk(input string nm, input exp_t got,
                     input exp_t want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc_now, got, want);
    end
  endtask

  task automatic chk_int(input string nm, input int got,
                         input int want);
    nvec++;
    if (got != want) begin
      nmis++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic tick(input int c);
    cyc_now = c;
    @(negedge clock);
    chk("model", dut_out(), model_out(m_act, m_k));
    if (tbl_on)
      foreach (tbl[i])
        if (tbl[i].cyc == c) chk("table", dut_out(), tbl[i].e);
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = c;
    end
    @(posedge clock);
    if (reset)
      m_act = 0;
    else if (m_act && bus.abort)
      m_act = 0;
    else if (m_act) begin
      if (m_k == N) m_act = 0;
      else m_k++;
    end else if (bus.start && !bus.abort) begin
      m_act = 1;
      m_k   = 0;
    end
    #1;
  endtask

  task automatic run_update(input int start2, input int abort_at,
                            input int rst_at, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      bus.start = (c == 0) || (c == start2);
      bus.abort = (c == abort_at);
      reset     = (c == rst_at);
      tick(c);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    tbl.push_back(mk( 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk( 3, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk( 4, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk( 5, 1, 0, 0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk( 8, 1, 0, 0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk( 9, 1, 0, 0, 0, 0, 1, 1, 1, 1));
    tbl.push_back(mk(10, 1, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(11, 1, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(12, 1, 0, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(19, 1, 0, 0, 2, 1, 0, 0, 1, 1));
    tbl.push_back(mk(25, 1, 0, 0, 2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(26, 1, 0, 0, 2, 0, 1, 0, 1, 1));
    tbl.push_back(mk(28, 1, 0, 1, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(32, 1, 0, 1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(54, 1, 0, 1, 2, 0, 1, 0, 1, 1));
    tbl.push_back(mk(55, 0, 1, 1, 2, 0, 1, 0, 1, 1));
    tbl.push_back(mk(56, 0, 0, 0, 0, 0, 1, 0, 1, 1));

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(posedge clock);
    #1;
    for (int c = 0; c < 3; c++) tick(c);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) tick(c);

    tbl_on   = 1;
    done_cnt = 0;
    run_update(-1, -1, -1, 60);
    chk_int("done_count", done_cnt, 1);
    chk_int("done_cycle", done_cyc, 55);

    done_cnt = 0;
    run_update(10, -1, -1, 60);
    chk_int("start_busy_done_count", done_cnt, 1);
    chk_int("start_busy_done_cycle", done_cyc, 55);
    tbl_on = 0;

    done_cnt = 0;
    run_update(-1, 20, -1, 30);
    chk_int("abort_no_done", done_cnt, 0);
    tbl_on = 1;
    run_update(-1, -1, -1, 60);
    tbl_on = 0;

    done_cnt = 0;
    run_update(-1, -1, 20, 30);
    chk_int("reset_no_done", done_cnt, 0);
    tbl_on = 1;
    run_update(-1, -1, -1, 60);
    tbl_on = 0;

    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick(0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int c = 1; c < 4; c++) tick(c);

    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom % 128) == 0;
      bus.abort = ($urandom % 48) == 0;
      bus.start = ($urandom % 6) == 0;
      tick(c);
    end
    reset     = 1'b0;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    tick(0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
